// File: rtl/datapath_seq_ctrl.sv
// Sequencer for the operand/ALU/result datapath: orders EA/EB, the ALU wait and EC,
// then holds done_o until the requester acknowledges.
module datapath_seq_ctrl #(
  parameter int ALU_LAT = 1,  // 1..15, fits the 4-bit wait counter
  parameter int CNT_W   = 8
) (
  input  logic             clk_sys,
  input  logic             rst_sys,
  input  logic             start_i,
  output logic             start_rdy_o,
  output logic             EA,
  output logic             EB,
  output logic             EC,
  output logic             busy_o,
  output logic             done_o,
  input  logic             done_ack_i,
  output logic [CNT_W-1:0] op_cnt_o,
  output logic             err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_CAPT,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [3:0]       r_wait;
  logic             r_rdy;
  logic             r_ld;
  logic             r_ec;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  // Every output is a flop updated together with the state, so none depends on an input.
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      r_state <= S_IDLE;
      r_wait  <= 4'd0;
      r_rdy   <= 1'b1;
      r_ld    <= 1'b0;
      r_ec    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_ld <= 1'b0;
      r_ec <= 1'b0;
      if (start_i && !r_rdy) begin
        r_err <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state <= S_LOAD;
            r_wait  <= 4'(ALU_LAT);
            r_rdy   <= 1'b0;
            r_busy  <= 1'b1;
            r_ld    <= 1'b1;
          end
        end
        S_LOAD: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // Leaving on a count of one gives exactly ALU_LAT cycles in WAIT.
          if (r_wait == 4'd1) begin
            r_state <= S_CAPT;
            r_wait  <= 4'd0;
            r_ec    <= 1'b1;
          end else begin
            r_wait <= r_wait - 4'd1;
          end
        end
        S_CAPT: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        S_DONE: begin
          if (done_ack_i) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
            r_rdy   <= 1'b1;
            r_busy  <= 1'b0;
            r_cnt   <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign start_rdy_o = r_rdy;
  assign EA          = r_ld;
  assign EB          = r_ld;
  assign EC          = r_ec;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign op_cnt_o    = r_cnt;
  assign err_o       = r_err;

endmodule

// File: tb/tb_datapath_seq_ctrl.sv
// Directed bench for datapath_seq_ctrl: five instances with different ALU latencies,
// a scoreboard of expected per-op results, sampled on the falling edge.
module tb_datapath_seq_ctrl;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic       rst_sys;
  logic [4:0] start, ack, rdy, ea, eb, ec, busy, done, err;
  logic [1:0] cnt [5];

  int n_chk  = 0;
  int n_pass = 0;

  function automatic int lat_of(input int i);
    case (i)
      0:       return 1;
      1:       return 2;
      2:       return 3;
      3:       return 4;
      default: return 15;
    endcase
  endfunction

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_dut
      datapath_seq_ctrl #(.ALU_LAT(lat_of(gi)), .CNT_W(2)) u_dut (
        .clk_sys    (clk_sys),
        .rst_sys    (rst_sys),
        .start_i    (start[gi]),
        .start_rdy_o(rdy[gi]),
        .EA         (ea[gi]),
        .EB         (eb[gi]),
        .EC         (ec[gi]),
        .busy_o     (busy[gi]),
        .done_o     (done[gi]),
        .done_ack_i (ack[gi]),
        .op_cnt_o   (cnt[gi]),
        .err_o      (err[gi])
      );
    end
  endgenerate

  typedef struct {
    int         idx;
    int         lat;
    logic [1:0] cnt;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] exp_cnt [5];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  // mode 0: start pulsed; 1: start held high afterwards; 2: held, dropped with the ack.
  task automatic run_op(input int i, input int hold, input int mode, input bit errp);
    int   t, ea_c, ec_c, dn_c, nea, neb, nec, ovl, drop;
    exp_t e;
    chk($sformatf("rdy_before_start[%0d]", i), rdy[i], 1);
    start[i]   = 1'b1;
    exp_cnt[i] = exp_cnt[i] + 2'd1;
    e.idx = i;
    e.lat = lat_of(i);
    e.cnt = exp_cnt[i];
    exp_q.push_back(e);
    @(posedge clk_sys);
    #1;
    if (mode == 0) start[i] = 1'b0;
    t = 0; ea_c = -1; ec_c = -1; dn_c = -1;
    nea = 0; neb = 0; nec = 0; ovl = 0; drop = 0;
    while (dn_c < 0 && t < 60) begin
      @(negedge clk_sys);
      t++;
      if (ea[i]) begin nea++; ea_c = t; end
      if (eb[i]) neb++;
      if (ec[i]) begin nec++; ec_c = t; end
      if (ea[i] && ec[i]) ovl++;
      if (done[i]) dn_c = t;
      if (errp && t == 2) start[i] = 1'b1;
      if (errp && t == 3) begin
        start[i] = 1'b0;
        chk("err_after_wait_start", err[i], 1);
      end
    end
    e = exp_q.pop_front();
    if (dn_c < 0) begin
      chk($sformatf("done_seen[%0d]", i), done[i], 1);
      start[i] = 1'b0;
      return;
    end
    repeat (hold) begin
      @(negedge clk_sys);
      if (!done[i]) drop++;
      if (ec[i]) nec++;
    end
    ack[i] = 1'b1;
    if (mode == 2) start[i] = 1'b0;
    @(negedge clk_sys);
    ack[i] = 1'b0;
    $display("op inst=%0d lat=%0d EA@%0d EC@%0d done@%0d hold=%0d cnt=%0d",
             e.idx, e.lat, ea_c, ec_c, dn_c, hold, cnt[e.idx]);
    chk("ea_cycle",   ea_c, 1);
    chk("ea_pulses",  nea, 1);
    chk("eb_pulses",  neb, 1);
    chk("ec_pulses",  nec, 1);
    chk("ec_cycle",   ec_c, e.lat + 2);
    chk("ea_to_ec",   ec_c - ea_c, e.lat + 1);
    chk("done_cycle", dn_c, e.lat + 3);
    chk("ea_ec_overlap", ovl, 0);
    if (hold > 0) chk("done_held", drop, 0);
    chk("op_cnt",     cnt[e.idx], e.cnt);
    chk("rdy_after_ack",  rdy[e.idx], 1);
    chk("done_after_ack", done[e.idx], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nec_rst;
    rst_sys = 1'b1;
    start   = '0;
    ack     = '0;
    for (int i = 0; i < 5; i++) exp_cnt[i] = 2'd0;

    // Reset state of every instance.
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rst_rdy[%0d]", i),  rdy[i], 1);
      chk($sformatf("rst_ea[%0d]", i),   ea[i], 0);
      chk($sformatf("rst_ec[%0d]", i),   ec[i], 0);
      chk($sformatf("rst_busy[%0d]", i), busy[i], 0);
      chk($sformatf("rst_done[%0d]", i), done[i], 0);
      chk($sformatf("rst_cnt[%0d]", i),  cnt[i], 0);
      chk($sformatf("rst_err[%0d]", i),  err[i], 0);
    end
    rst_sys = 1'b0;

    // Reset in the middle of WAIT on the ALU_LAT=3 instance.
    @(negedge clk_sys);
    start[2] = 1'b1;
    @(posedge clk_sys);
    #1;
    start[2] = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys);
    chk("midrst_in_wait_busy", busy[2], 1);
    rst_sys = 1'b1;
    @(negedge clk_sys);
    rst_sys = 1'b0;
    chk("midrst_ea",   ea[2], 0);
    chk("midrst_eb",   eb[2], 0);
    chk("midrst_ec",   ec[2], 0);
    chk("midrst_done", done[2], 0);
    chk("midrst_rdy",  rdy[2], 1);
    chk("midrst_busy", busy[2], 0);
    chk("midrst_cnt",  cnt[2], 0);
    chk("midrst_err",  err[2], 0);
    nec_rst = 0;
    repeat (10) begin
      @(negedge clk_sys);
      if (ec[2]) nec_rst++;
    end
    chk("midrst_no_ec", nec_rst, 0);
    $display("op inst=2 lat=3 reset mid-WAIT, EC pulses after reset=%0d", nec_rst);

    // Single op, ALU_LAT=1, immediate ack.
    run_op(0, 0, 0, 1'b0);

    // Done held for 10 cycles, ALU_LAT=4.
    run_op(3, 10, 0, 1'b0);

    // Start during WAIT sets the sticky error; the op still completes.
    run_op(1, 0, 0, 1'b1);
    run_op(1, 0, 0, 1'b0);
    chk("err_sticky", err[1], 1);

    // Counter wrap on CNT_W=2 with start held high throughout.
    run_op(2, 0, 1, 1'b0);
    run_op(2, 0, 1, 1'b0);
    run_op(2, 0, 1, 1'b0);
    run_op(2, 0, 1, 1'b0);
    run_op(2, 0, 2, 1'b0);
    chk("wrap_err", err[2], 1);

    // Latency sweep.
    run_op(0, 0, 0, 1'b0);
    run_op(1, 0, 0, 1'b0);
    run_op(4, 0, 0, 1'b0);
    chk("sweep_err_clean", err[4], 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
